dmem_burst_master: RTL and testbench

// - Initiator for the 64-bit data-memory port: addr[15:0], inputData[63:0], writeEnable, out[63:0].
// - Memory reads are registered with 1-cycle latency; during a write, out returns the written data.
// - Turns one command (base, length, direction) into a burst of word accesses.
// - Streams write data in, and read data out through a buffered valid/ready interface.
// - Sits between the vector load/store stage and dataMemory.

---
 rtl/dmem_burst_pkg.sv | 17 +
 rtl/burst_fifo.sv | 57 +++++
 rtl/dmem_burst_master.sv | 180 ++++++++++++++++++
 tb/tb_dmem_burst_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_burst_pkg.sv
// Shared widths and FSM state encoding for the data-memory burst master.
package dmem_burst_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned LEN_W         = 8;
    localparam int unsigned MEM_WORDS_DEF = 49152;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/burst_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
module burst_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_burst_master.sv
// Burst initiator for the 64-bit data memory: one command becomes len word accesses.
// Optional counters perf_words/perf_stalls are built when DMEM_BURST_PERF_EN is defined.
module dmem_burst_master
    import dmem_burst_pkg::*;
#(
    parameter int unsigned RD_FIFO_DEPTH = 4,
    parameter int unsigned MEM_WORDS     = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_inputData,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef DMEM_BURST_PERF_EN
    ,
    output logic [31:0]       perf_words,
    output logic [31:0]       perf_stalls
`endif
);

    localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam int unsigned SUM_W = ADDR_W + 1;

    state_e            state;
    state_e            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              err_q;
    logic              rd_v1;
    logic              rd_v2;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [SUM_W-1:0]  cmd_end;
    logic [CRD_W-1:0]  credit_used;
    logic              cmd_illegal;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_issue;
    logic              rd_pop;
    logic              last_idx;

    assign cmd_end     = SUM_W'(cmd_base) + SUM_W'(cmd_len);
    assign cmd_illegal = (cmd_len == '0) || (cmd_end > SUM_W'(MEM_WORDS));
    assign cmd_fire    = (state == ST_IDLE) && cmd_valid;
    assign wr_fire     = (state == ST_WR) && wdata_valid;
    assign last_idx    = (idx_q == len_q - LEN_W'(1));

    // Reads still in the memory pipeline hold a FIFO slot, so the buffer cannot overflow.
    assign credit_used = CRD_W'(fifo_count) + CRD_W'(rd_v1) + CRD_W'(rd_v2);
    assign rd_issue    = (state == ST_RD) && !fifo_full
                         && (credit_used < CRD_W'(RD_FIFO_DEPTH));
    assign rd_pop      = rdata_ready && !fifo_empty
                         && ((state == ST_RD) || (state == ST_DRAIN));

    assign cmd_ready   = (state == ST_IDLE);
    assign wdata_ready = (state == ST_WR);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = (state == ST_DONE) && err_q;
    assign rdata_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal)    state_nx = ST_DONE;
                    else if (cmd_write) state_nx = ST_WR;
                    else                state_nx = ST_RD;
                end
            end
            ST_WR:    if (wr_fire && last_idx)  state_nx = ST_DONE;
            ST_RD:    if (rd_issue && last_idx) state_nx = ST_DRAIN;
            // Finish on the cycle that pops the final buffered word.
            ST_DRAIN: if (!rd_v1 && !rd_v2
                          && (fifo_empty || ((fifo_count == CNT_W'(1)) && rd_pop)))
                          state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Command latch, word index and registered memory-port drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q          <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            err_q           <= 1'b0;
            rd_v1           <= 1'b0;
            rd_v2           <= 1'b0;
            mem_address     <= '0;
            mem_inputData   <= '0;
            mem_writeEnable <= 1'b0;
        end else begin
            rd_v1           <= rd_issue;
            rd_v2           <= rd_v1;
            mem_writeEnable <= wr_fire;
            if (cmd_fire) begin
                base_q <= cmd_base;
                len_q  <= cmd_len;
                idx_q  <= '0;
                err_q  <= cmd_illegal;
            end
            if (wr_fire) begin
                mem_address   <= base_q + ADDR_W'(idx_q);
                mem_inputData <= wdata;
                idx_q         <= idx_q + LEN_W'(1);
            end else if (rd_issue) begin
                mem_address <= base_q + ADDR_W'(idx_q);
                idx_q       <= idx_q + LEN_W'(1);
            end
        end
    end

    burst_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_v2),
        .pop   (rd_pop),
        .din   (mem_out),
        .dout  (rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef DMEM_BURST_PERF_EN
    logic word_moved;
    logic burst_active;

    assign word_moved   = wr_fire || rd_pop;
    assign burst_active = (state == ST_WR) || (state == ST_RD) || (state == ST_DRAIN);

    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words  <= '0;
            perf_stalls <= '0;
        end else begin
            if (word_moved && (perf_words != '1)) begin
                perf_words <= perf_words + 32'd1;
            end
            if (burst_active && !word_moved && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_burst_master.sv
// Bench for dmem_burst_master: vector table, corner sequences and random commands vs a shadow memory.
`timescale 1ns/1ps
module tb_dmem_burst_master;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MW    = 49152;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_base;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [63:0] rdata;
    logic [15:0] mem_address;
    logic [63:0] mem_inputData;
    logic        mem_writeEnable;
    logic [63:0] mem_out = '0;
    logic        busy, done, err;
`ifdef DMEM_BURST_PERF_EN
    logic [31:0] perf_words, perf_stalls;
`endif

    logic [63:0] memm   [MW];
    logic [63:0] shadow [MW];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_burst_master #(.RD_FIFO_DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .mem_address(mem_address), .mem_inputData(mem_inputData),
        .mem_writeEnable(mem_writeEnable), .mem_out(mem_out),
        .busy(busy), .done(done), .err(err)
`ifdef DMEM_BURST_PERF_EN
        , .perf_words(perf_words), .perf_stalls(perf_stalls)
`endif
    );

    function automatic logic [63:0] init_word(input int a);
        return {16'hC0DE, 16'(a), 32'(a) * 32'h9E3779B1};
    endfunction

    // Data memory: registered read, write-through on out.
    always @(posedge clk) begin
        if (mem_writeEnable) begin
            if (int'(mem_address) < int'(MW)) memm[mem_address] <= mem_inputData;
            mem_out <= mem_inputData;
        end else begin
            mem_out <= (int'(mem_address) < int'(MW)) ? memm[mem_address] : 64'd0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drives one command to completion; data checked against the shadow memory.
    task automatic run_cmd(input bit wr, input logic [15:0] base, input logic [7:0] len,
                           input int stall, input int vmode, input int rmode, input int probe,
                           input logic [63:0] dseed, output bit err_seen, output int lat);
        logic [63:0] wq [$];
        bit ill, accepted, fin;
        int cyc, acc_cyc, nw, nr, wi, bad_w, bad_r, exp_n;
        ill = (len == 8'd0) || (int'(base) + int'(len) > int'(MW));
        for (int i = 0; i < int'(len); i++)
            wq.push_back((dseed != 64'd0) ? dseed + 64'(i) : {$urandom, $urandom});
        accepted = 0; fin = 0; cyc = 0; acc_cyc = 0; nw = 0; nr = 0; wi = 0;
        bad_w = 0; bad_r = 0; err_seen = 0; lat = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_len = len;
        while (!fin && cyc < 4000) begin
            if (mem_writeEnable) begin
                if (!(nw < wq.size() && mem_address == base + 16'(nw) && mem_inputData == wq[nw]))
                    bad_w++;
                nw++;
            end
            if (done) begin
                fin = 1; err_seen = err; lat = cyc - acc_cyc;
            end
            if (probe == cyc) check("stall_issue_addr", 64'(mem_address), 64'(base + 16'(DEPTH - 1)));
            if (accepted) cmd_valid = 1'b0;
            else if (cmd_ready) begin accepted = 1; acc_cyc = cyc; end
            if (wr && wi < int'(len)) begin
                wdata = wq[wi];
                case (vmode)
                    0:       wdata_valid = 1'b1;
                    1:       wdata_valid = (cyc % 2) == 1;
                    default: wdata_valid = 1'($urandom_range(0, 1));
                endcase
                if (wdata_valid && wdata_ready) wi++;
            end else begin
                wdata_valid = 1'b0;
            end
            if (cyc < stall) rdata_ready = 1'b0;
            else begin
                case (rmode)
                    0:       rdata_ready = 1'b1;
                    1:       rdata_ready = (cyc % 2) == 0;
                    default: rdata_ready = 1'($urandom_range(0, 1));
                endcase
            end
            if (rdata_ready && rdata_valid) begin
                if (!(nr < int'(len) && int'(base) + nr < int'(MW)
                      && rdata == shadow[int'(base) + nr]))
                    bad_r++;
                nr++;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
        check("done_seen", 64'(fin), 64'd1);
        exp_n = ill ? 0 : int'(len);
        check("wr_count", 64'(nw), wr ? 64'(exp_n) : 64'd0);
        check("wr_data", 64'(bad_w), 64'd0);
        check("rd_count", 64'(nr), wr ? 64'd0 : 64'(exp_n));
        check("rd_data", 64'(bad_r), 64'd0);
        if (wr && !ill)
            for (int i = 0; i < int'(len); i++) shadow[int'(base) + i] = wq[i];
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] base;
        logic [7:0]  len;
        int          stall;
        int          vmode;
        int          rmode;
        int          probe;
        logic [63:0] dseed;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t tbl [11];
        bit   e;
        int   lat, first_done, second_acc;
`ifdef DMEM_BURST_PERF_EN
        logic [31:0] ps0, pw0;
`endif
        for (int i = 0; i < int'(MW); i++) begin
            memm[i]   = init_word(i);
            shadow[i] = init_word(i);
        end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(mem_writeEnable), 64'd0);
        check("rst_rvalid", 64'(rdata_valid), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        rst_n = 1'b1;

        tbl[0]  = '{1'b1, 16'h0010,   8'd4,  0, 0, 0, -1, 64'hA, 1'b0};
        tbl[1]  = '{1'b0, 16'h0010,   8'd4,  0, 0, 0, -1, 64'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0100,  8'd16, 20, 0, 0, 20, 64'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'hBFFF,   8'd2,  0, 0, 0, -1, 64'd0, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000,   8'd0,  0, 0, 0, -1, 64'd0, 1'b1};
        tbl[5]  = '{1'b1, 16'hBFFE,   8'd2,  0, 0, 0, -1, 64'd0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0200,   8'd8,  0, 1, 0, -1, 64'd0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0200,   8'd8,  0, 0, 1, -1, 64'd0, 1'b0};
        tbl[8]  = '{1'b0, 16'hBFFE,   8'd2,  0, 0, 0, -1, 64'd0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0300, 8'd255,  0, 0, 0, -1, 64'd0, 1'b0};
        tbl[10] = '{1'b0, 16'h0300, 8'd255,  3, 0, 2, -1, 64'd0, 1'b0};

        for (int i = 0; i < 11; i++) begin
`ifdef DMEM_BURST_PERF_EN
            ps0 = perf_stalls; pw0 = perf_words;
`endif
            run_cmd(tbl[i].wr, tbl[i].base, tbl[i].len, tbl[i].stall, tbl[i].vmode,
                    tbl[i].rmode, tbl[i].probe, tbl[i].dseed, e, lat);
            check("tbl_err", 64'(e), 64'(tbl[i].exp_err));
            if (tbl[i].exp_err) check("ill_done_lat", 64'(lat), 64'd1);
`ifdef DMEM_BURST_PERF_EN
            if (i == 6) begin
                check("perf_stalls", 64'(perf_stalls - ps0), 64'd7);
                check("perf_words", 64'(perf_words - pw0), 64'd8);
            end
`endif
        end

        // Reset in the middle of a 32-word load.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 16'h0400; cmd_len = 8'd32; rdata_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_rvalid", 64'(rdata_valid), 64'd0);
        check("arst_rdata", rdata, 64'd0);
        check("arst_addr", 64'(mem_address), 64'd0);
        check("arst_wdata", mem_inputData, 64'd0);
        check("arst_we", 64'(mem_writeEnable), 64'd0);
        check("arst_done_err", 64'({done, err, wdata_ready}), 64'd0);
        @(negedge clk);
        rdata_ready = 1'b0; rst_n = 1'b1;
        run_cmd(1'b0, 16'h0123, 8'd1, 0, 0, 0, -1, 64'd0, e, lat);
        check("post_rst_err", 64'(e), 64'd0);

        // Back-to-back commands with cmd_valid held high.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 16'h0010; cmd_len = 8'd2; rdata_ready = 1'b1;
        first_done = -1; second_acc = -1;
        for (int c = 0; c < 200 && second_acc < 0; c++) begin
            if (done && first_done < 0) first_done = c;
            if (c > 0 && cmd_ready) second_acc = c;
            if (second_acc < 0) @(negedge clk);
        end
        check("b2b_gap", 64'(second_acc - first_done), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        e = 0;
        for (int c = 0; c < 200 && !e; c++) begin
            if (done) e = 1;
            else @(negedge clk);
        end
        check("b2b_done2", 64'(e), 64'd1);
        rdata_ready = 1'b0;

        // Random commands, legal and illegal, with random handshake patterns.
        for (int k = 0; k < 30; k++) begin
            bit          w, ill;
            logic [15:0] b;
            logic [7:0]  l;
            int          sel;
            sel = int'($urandom_range(0, 9));
            w   = 1'($urandom_range(0, 1));
            l   = 8'($urandom_range(1, 40));
            if (sel == 0) l = 8'd0;
            if (sel <= 2)      b = 16'($urandom_range(0, 65535));
            else if (sel == 3) b = 16'(int'(MW) - int'(l) + int'($urandom_range(0, 1)));
            else               b = 16'($urandom_range(0, 4095));
            ill = (l == 8'd0) || (int'(b) + int'(l) > int'(MW));
            run_cmd(w, b, l, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), -1, 64'd0, e, lat);
            check("rand_err", 64'(e), 64'(ill));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
